// File: rtl/prng_rand_dispenser_pkg.sv
// Shared types and constants for the PRNG random-word dispenser.
// The warm-up length follows from the Trivium initialisation round count.
package prng_rand_dispenser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESEED = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

    localparam int PRNG_WORD_W          = 64;
    localparam int TRIVIUM_INIT_ROUNDS  = 1152;
    localparam int WARMUP_WORDS_DEFAULT = TRIVIUM_INIT_ROUNDS / PRNG_WORD_W;

    // Index width that stays legal (>=1 bit) even for a single-entry range.
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/prng_rand_dispenser_word_fifo.sv
// Synchronous DEPTH x 64 word FIFO with flush; a push while full is
// accepted only when a pop completes in the same cycle.
module prng_word_fifo
    import prng_rand_dispenser_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [PRNG_WORD_W-1:0]  wr_data,
    output logic [PRNG_WORD_W-1:0]  rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);

    logic [PRNG_WORD_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]          wr_ptr_r;
    logic [PW-1:0]          rd_ptr_r;
    logic [PW:0]            count_r;
    logic                   push_ok_s;
    logic                   pop_ok_s;

    assign full      = (count_r == (PW+1)'(DEPTH));
    assign empty     = (count_r == (PW+1)'(0));
    assign push_ok_s = push && (!full || pop_ok_s);
    assign pop_ok_s  = pop && !empty;
    assign count     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; flush overrides push and pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= (PW+1)'(0);
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Word storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/prng_rand_dispenser.sv
// Consumer side of the 64-bit Trivium PRNG: reseeds, discards warm-up words,
// buffers words and serves them as RW-bit chunks over valid/ready.
module prng_rand_dispenser
    import prng_rand_dispenser_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int RW           = 32,
    parameter int WARMUP_WORDS = WARMUP_WORDS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    seed_req,
    output logic                    reseed,
    input  logic                    prng_valid,
    input  logic [PRNG_WORD_W-1:0]  prng_out,
    output logic [RW-1:0]           rand_out,
    output logic                    rand_valid,
    input  logic                    rand_ready,
    output logic                    run,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  fill_level
);

    localparam int NCHUNK = PRNG_WORD_W / RW;
    localparam int KW     = idx_width(NCHUNK);
    localparam int WW     = idx_width(WARMUP_WORDS);
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);
    localparam logic [WW-1:0] W_LAST = WW'(WARMUP_WORDS - 1);

    state_e                 state_r;
    state_e                 state_s;
    logic                   reseed_r;
    logic                   overflow_r;
    logic [KW-1:0]          k_r;
    logic [WW-1:0]          warm_r;
    logic                   go_reseed_s;
    logic                   hs_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   drop_s;
    logic                   full_s;
    logic                   empty_s;
    logic [PRNG_WORD_W-1:0] head_s;
    logic [$clog2(DEPTH):0] count_s;

    prng_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (go_reseed_s),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (prng_out),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_s)
    );

    // Next-state, handshake, push/drop decisions.
    always_comb begin
        go_reseed_s = seed_req && (state_r != ST_RESEED);
        hs_s        = !empty_s && rand_ready;
        pop_s       = hs_s && (k_r == K_LAST);
        push_s      = 1'b0;
        drop_s      = 1'b0;
        state_s     = state_r;
        if (go_reseed_s) begin
            state_s = ST_RESEED;
        end else begin
            case (state_r)
                ST_IDLE:   state_s = ST_IDLE;
                ST_RESEED: state_s = ST_WARMUP;
                ST_WARMUP: begin
                    if (prng_valid && (warm_r == W_LAST)) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_WARMUP;
                    end
                end
                ST_RUN: begin
                    state_s = ST_RUN;
                    if (prng_valid) begin
                        push_s = !full_s || pop_s;
                        drop_s = full_s && !pop_s;
                    end else begin
                        push_s = 1'b0;
                        drop_s = 1'b0;
                    end
                end
                default:   state_s = ST_IDLE;
            endcase
        end
    end

    // FSM register, registered reseed pulse, warm-up counter, sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            reseed_r   <= 1'b0;
            warm_r     <= WW'(0);
            overflow_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            reseed_r <= go_reseed_s;
            if (go_reseed_s) begin
                warm_r <= WW'(0);
            end else if ((state_r == ST_WARMUP) && prng_valid) begin
                warm_r <= warm_r + WW'(1);
            end
            if (drop_s) overflow_r <= 1'b1;
        end
    end

    // Chunk index within the head word; a reseed discards any partial word.
    always_ff @(posedge clk) begin
        if (reset || go_reseed_s) begin
            k_r <= KW'(0);
        end else if (hs_s) begin
            k_r <= pop_s ? KW'(0) : k_r + KW'(1);
        end
    end

    assign rand_valid = !empty_s;
    assign rand_out   = rand_valid ? head_s[int'(k_r) * RW +: RW] : RW'(0);
    assign reseed     = reseed_r;
    assign run        = (state_r == ST_RUN);
    assign overflow   = overflow_r;
    assign fill_level = count_s;

endmodule

// File: tb/tb_prng_rand_dispenser.sv
// Scoreboard bench for prng_rand_dispenser: a behavioural model queues the
// expected chunks of every accepted word; a monitor pops them on handshakes.
module tb_prng_rand_dispenser;

    localparam int DEPTH = 4;
    localparam int RW    = 32;
    localparam int WARM  = 18;
    localparam int NCH   = 64 / RW;

    logic                   clk        = 1'b0;
    logic                   reset      = 1'b1;
    logic                   seed_req   = 1'b0;
    logic                   prng_valid = 1'b0;
    logic                   rand_ready = 1'b0;
    logic [63:0]            prng_out   = 64'd0;
    logic                   reseed;
    logic                   rand_valid;
    logic                   run;
    logic                   overflow;
    logic [RW-1:0]          rand_out;
    logic [$clog2(DEPTH):0] fill_level;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    bit use_rand = 1'b0;

    typedef enum int {P_IDLE, P_RESEED, P_WARMUP, P_RUN} phase_t;
    phase_t        m_phase  = P_IDLE;
    int            m_words  = 0;
    int            m_k      = 0;
    int            m_warm   = 0;
    bit            m_ovf    = 1'b0;
    bit            m_reseed = 1'b0;
    bit            m_hs;
    bit            m_pop;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp_chunk;

    prng_rand_dispenser #(
        .DEPTH        (DEPTH),
        .RW           (RW),
        .WARMUP_WORDS (WARM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seed_req   (seed_req),
        .reseed     (reseed),
        .prng_valid (prng_valid),
        .prng_out   (prng_out),
        .rand_out   (rand_out),
        .rand_valid (rand_valid),
        .rand_ready (rand_ready),
        .run        (run),
        .overflow   (overflow),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (use_rand) prng_out = {$urandom(), $urandom()};
        else          prng_out = {~32'(cyc), 32'(cyc)};
    endtask

    // Reference model: words seen, words buffered, chunk position, sticky drop flag.
    always @(posedge clk) begin
        if (reset) begin
            m_phase = P_IDLE; m_words = 0; m_k = 0; m_warm = 0;
            m_ovf = 1'b0; m_reseed = 1'b0;
            exp_q.delete();
        end else begin
            m_hs     = (m_words != 0) && rand_ready;
            m_pop    = m_hs && (m_k == NCH - 1);
            m_reseed = seed_req && (m_phase != P_RESEED);
            if (m_reseed) begin
                m_phase = P_RESEED; m_words = 0; m_k = 0; m_warm = 0;
                exp_q.delete();
            end else begin
                if (m_hs)  m_k = m_pop ? 0 : m_k + 1;
                if (m_pop) m_words--;
                case (m_phase)
                    P_RESEED: m_phase = P_WARMUP;
                    P_WARMUP: if (prng_valid) begin
                        m_warm++;
                        if (m_warm == WARM) m_phase = P_RUN;
                    end
                    P_RUN: if (prng_valid) begin
                        if (m_words < DEPTH) begin
                            m_words++;
                            for (int c = 0; c < NCH; c++) exp_q.push_back(prng_out[c*RW +: RW]);
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor: status against the model, chunks against the expected queue.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("reseed", reseed, m_reseed);
            chk("run", run, m_phase == P_RUN);
            chk("rand_valid", rand_valid, m_words != 0);
            chk("fill_level", fill_level, m_words);
            chk("overflow", overflow, m_ovf);
            if (rand_valid && rand_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL chunk: actual=%0h required=none (cycle %0d)", rand_out, cyc);
                end else begin
                    exp_chunk = exp_q.pop_front();
                    chk("chunk", rand_out, exp_chunk);
                end
            end
        end
    end

    initial begin
        int          n;
        int          seed_cyc;
        logic [63:0] first_word;

        // Test 1: reset, seed at cycle 5, counter-valued words
        reset = 1'b1; prng_valid = 1'b1; rand_ready = 1'b0;
        step(); mon_en = 1'b1; step(); step();
        chk("reset_rand_out", rand_out, 64'd0);
        chk("reset_reseed", reseed, 64'd0);
        reset = 1'b0;
        while (cyc < 5) step();
        seed_req = 1'b1; seed_cyc = cyc;
        step();
        seed_req = 1'b0;
        chk("reseed_cycle", cyc, 64'd6);
        chk("reseed_high", reseed, 64'd1);
        n = 0;
        while (!run && n < 100) begin step(); n++; end
        chk("run_latency", cyc - seed_cyc, 2 + WARM);
        step();
        chk("first_chunk", rand_out, 32'(seed_cyc + 2 + WARM));

        // Test 3: continuous ready, one word per NCH cycles
        use_rand = 1'b1; prng_valid = 1'b0; rand_ready = 1'b1;
        repeat (8) step();
        for (int i = 0; i < 40; i++) begin
            prng_valid = (i % NCH == 0);
            step();
            chk("t3_fill_le1", fill_level <= 1, 64'd1);
        end
        chk("t3_no_overflow", overflow, 64'd0);

        // Test 4: full FIFO, last chunk popped while a word is pushed
        prng_valid = 1'b0; repeat (6) step();
        rand_ready = 1'b0; prng_valid = 1'b1;
        repeat (4) step();
        chk("t4_full", fill_level, DEPTH);
        prng_valid = 1'b0; rand_ready = 1'b1;
        step();
        prng_valid = 1'b1;
        step();
        chk("t4_fill_kept", fill_level, DEPTH);
        chk("t4_no_overflow", overflow, 64'd0);

        // Test 2: stall until full, fifth word dropped, then drain in order
        prng_valid = 1'b0; rand_ready = 1'b1;
        repeat (10) step();
        rand_ready = 1'b0; prng_valid = 1'b1; first_word = prng_out;
        repeat (4) step();
        chk("t2_fill4", fill_level, DEPTH);
        chk("t2_ovf_before", overflow, 64'd0);
        step();
        chk("t2_ovf_set", overflow, 64'd1);
        chk("t2_head", rand_out, first_word[RW-1:0]);
        rand_ready = 1'b1;
        repeat (20) step();

        // Test 5: reseed with two words buffered and a partial word
        prng_valid = 1'b0; repeat (10) step();
        rand_ready = 1'b0; prng_valid = 1'b1;
        repeat (2) step();
        prng_valid = 1'b0; rand_ready = 1'b1;
        step();
        rand_ready = 1'b0; seed_req = 1'b1; seed_cyc = cyc;
        step();
        seed_req = 1'b0;
        chk("t5_valid_drop", rand_valid, 64'd0);
        chk("t5_fill0", fill_level, 64'd0);
        chk("t5_reseed", reseed, 64'd1);
        chk("t5_ovf_kept", overflow, 64'd1);
        prng_valid = 1'b1;
        n = 0;
        while (!run && n < 100) begin step(); n++; end
        chk("t5_run_latency", cyc - seed_cyc, 2 + WARM);

        // Test 6: reset during warm-up, no writes without a new seed
        seed_req = 1'b1; step(); seed_req = 1'b0;
        repeat (6) step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("t6_run", run, 64'd0);
        chk("t6_reseed", reseed, 64'd0);
        chk("t6_ovf", overflow, 64'd0);
        chk("t6_valid", rand_valid, 64'd0);
        chk("t6_fill", fill_level, 64'd0);
        chk("t6_rand_out", rand_out, 64'd0);
        repeat (30) step();
        chk("t6_no_writes", fill_level, 64'd0);

        // Randomised traffic with occasional reseeds
        seed_req = 1'b1; step(); seed_req = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            prng_valid = ($urandom_range(0, 3) != 0);
            rand_ready = ($urandom_range(0, 1) != 0);
            seed_req   = ($urandom_range(0, 149) == 0);
            step();
        end
        seed_req = 1'b0; prng_valid = 1'b0; rand_ready = 1'b1;
        repeat (20) step();
        chk("drain_queue_empty", exp_q.size(), 64'd0);
        chk("drain_fill0", fill_level, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prng_rand_dispenser.md
Name: prng_rand_dispenser

Overview:
- Consumer-side counterpart of the 64-bit Trivium PRNG.
- Issues the `reseed` pulse to the PRNG and discards warm-up words after each reseed.
- Buffers accepted 64-bit words in a small FIFO and serves them to masked AES gadgets as RW-bit chunks over a valid/ready handshake.
- The PRNG has no backpressure, so this block also detects and flags dropped words.

Parameters:
- DEPTH, 4, FIFO depth in 64-bit words; power of two, 2..16.
- RW, 32, chunk width delivered per handshake; one of 8, 16, 32, 64.
- WARMUP_WORDS, 18, number of prng_valid words discarded after each reseed (1152 Trivium rounds / 64).

Ports:
- clk  input  1  single clock domain; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- seed_req  input  1  one-cycle request to (re)seed the PRNG.
- reseed  output  1  to PRNG `reseed`; one-cycle pulse.
- prng_valid  input  1  PRNG valid; stays high once set, including across reseeds.
- prng_out  input  64  PRNG word; a new word arrives every cycle while valid.
- rand_out  output  RW  current chunk.
- rand_valid  output  1  chunk available.
- rand_ready  input  1  consumer accepts the chunk.
- run  output  1  high in RUN state.
- overflow  output  1  sticky: a post-warm-up word was dropped because the FIFO was full.
- fill_level  output  $clog2(DEPTH)+1  words currently in the FIFO.

Behaviour:
- Reset values:
  - state=IDLE.
  - reseed=0, rand_valid=0, rand_out=0, run=0, overflow=0, fill_level=0.
  - FIFO pointers, chunk index and warm-up counter all 0.
- FSM states: IDLE, RESEED, WARMUP, RUN.
- IDLE:
  - No words are accepted.
  - On seed_req -> RESEED.
- RESEED (one cycle):
  - reseed=1 is registered, so it is high exactly one cycle after seed_req is sampled.
  - The FIFO is flushed: pointers=0, chunk index=0, fill_level=0 the next cycle.
  - The warm-up counter is cleared. Next state is WARMUP.
- WARMUP:
  - Each cycle with prng_valid=1 increments the counter; the word is discarded.
  - When the counter reaches WARMUP_WORDS-1 with prng_valid=1 -> RUN. That final word is also discarded.
  - The first word written to the FIFO is the next prng_valid word.
- RUN:
  - Each cycle with prng_valid=1 and fill_level<DEPTH: prng_out is written to the FIFO.
  - If fill_level==DEPTH and no pop completes in the same cycle: the word is dropped and overflow is set.
  - A simultaneous pop of the last chunk and a push when full is allowed: the push succeeds and fill_level is unchanged.
- Output side:
  - rand_valid = (fill_level!=0).
  - rand_out = head word bits [RW*k+RW-1 : RW*k], where k is the chunk index (LSB chunk first).
  - Handshake completes when rand_valid && rand_ready.
  - On completion, k increments. At k = 64/RW-1 the head word is popped and k wraps to 0.
  - When RW=64, every handshake pops a word.
  - rand_out is not required to be stable while rand_valid=0. It must be stable while rand_valid=1 and rand_ready=0.
  - The consumer may hold rand_ready high continuously; throughput is then one chunk per cycle.
- seed_req in WARMUP or RUN:
  - Returns to RESEED, flushes the FIFO, and discards any partial word.
  - rand_valid drops the cycle after seed_req is sampled.
  - overflow is not cleared.
- seed_req while in RESEED is ignored.
- overflow is cleared only by reset.
- Reset mid-operation: all state returns to reset values the next cycle. No reseed pulse is emitted.
- Latency:
  - From seed_req to run=1: 2 cycles + WARMUP_WORDS cycles in which prng_valid=1.
  - From a push to rand_valid: 1 cycle, since the FIFO is registered.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE/RESEED/WARMUP/RUN).
  - PRNG_WORD_W=64 constant.
  - TRIVIUM_INIT_ROUNDS=1152 constant, from which WARMUP_WORDS is derived.
- One sub-module: prng_word_fifo.
  - Synchronous, DEPTH x 64, with flush, push, pop, full, empty and count.
- FSM and chunk selection stay in the top module.

Test Plan:
1. Reset, then seed_req at cycle 5 with prng_valid held 1 and prng_out = cycle counter.
   - Required: reseed high only at cycle 6.
   - run rises after 18 valid words.
   - First chunk delivered comes from the 19th post-reseed word; RW=32 gives its low half first.
2. RUN with rand_ready=0 and DEPTH=4.
   - Required: fill_level reaches 4 after 4 words; the 5th word sets overflow=1.
   - Head is still the first word.
   - Raise rand_ready: chunks come out in FIFO order with no gaps.
3. rand_ready=1 continuously with RW=16.
   - Required: 4 handshakes per word; the word is popped on the 4th.
   - Steady-state fill_level stays 0 or 1; overflow stays 0.
4. Full FIFO, last chunk popped in the same cycle as a push.
   - Required: no overflow; fill_level stays 4.
5. seed_req mid-RUN with 2 words buffered and k=1.
   - Required: rand_valid=0 next cycle; reseed pulses once.
   - fill_level=0; run=0 until warm-up completes; overflow unchanged.
6. Reset asserted during WARMUP.
   - Required: state returns to IDLE; all outputs 0.
   - No FIFO writes until a new seed_req.
